mux_pipe_n: RTL and testbench

Parametrised, registered N-to-1 operand-select stage for the pipeline datapath, generalising the plain two-input select. Each cycle it selects one of N WIDTH-bit words with a binary select and captures the result, plus select-error status, into a 2-entry skid buffer. The buffer has valid/ready handshakes on both sides and a synchronous flush. It sits between the register-file/forwarding sources and the EX-stage operand registers, where stalls (out_ready low) and branch flushes must not drop or duplicate operands.

---
 rtl/mux_pipe_n_if.sv | 29 ++
 rtl/mux_pipe_n.sv | 115 +++++++++++
 tb/tb_mux_pipe_n.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_pipe_n_if.sv
// Operand-select stage bus: upstream word/select offer and downstream registered result.
// master drives the stage (source + sink side), slave is the stage itself.
interface mux_pipe_n_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
);
    localparam int unsigned SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]   sel;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_err;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid
    );

    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid
    );
endinterface

// File: rtl/mux_pipe_n.sv
// Registered N-to-1 operand select feeding a 2-entry skid buffer (head/tail FIFO)
// with valid/ready on both sides and a synchronous flush.
module mux_pipe_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
) (
    input logic         clk,
    input logic         rst_n,
    mux_pipe_n_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(N);

    typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StFull = 2'd2} state_e;

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] h_data_q, h_data_d, t_data_q, t_data_d;
    logic [SEL_W-1:0] h_sel_q, h_sel_d, t_sel_q, t_sel_d;
    logic             h_err_q, h_err_d, t_err_q, t_err_d;

    logic [WIDTH-1:0] new_data;
    logic             new_err;
    logic             push, pop;

    assign push = bus.in_valid && in_ready_q;
    assign pop  = (state_q != StEmpty) && bus.out_ready;

    // Out-of-range selects (non power-of-two N) fall through with err set and zero data.
    always_comb begin
        new_data = '0;
        new_err  = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                new_data = bus.in_data[i*WIDTH +: WIDTH];
                new_err  = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        h_data_d = h_data_q;
        h_sel_d  = h_sel_q;
        h_err_d  = h_err_q;
        t_data_d = t_data_q;
        t_sel_d  = t_sel_q;
        t_err_d  = t_err_q;
        if (bus.flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d  = StOne;
                        h_data_d = new_data;
                        h_sel_d  = bus.sel;
                        h_err_d  = new_err;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        h_data_d = new_data;
                        h_sel_d  = bus.sel;
                        h_err_d  = new_err;
                    end else if (push) begin
                        state_d  = StFull;
                        t_data_d = new_data;
                        t_sel_d  = bus.sel;
                        t_err_d  = new_err;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_d  = StOne;
                        h_data_d = t_data_q;
                        h_sel_d  = t_sel_q;
                        h_err_d  = t_err_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b0;
            h_data_q   <= '0;
            h_sel_q    <= '0;
            h_err_q    <= 1'b0;
            t_data_q   <= '0;
            t_sel_q    <= '0;
            t_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            h_data_q   <= h_data_d;
            h_sel_q    <= h_sel_d;
            h_err_q    <= h_err_d;
            t_data_q   <= t_data_d;
            t_sel_q    <= t_sel_d;
            t_err_q    <= t_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != StEmpty);
    assign bus.out_data  = h_data_q;
    assign bus.out_sel   = h_sel_q;
    assign bus.out_err   = h_err_q;
endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: scoreboarded N=4 instance plus a directed N=3 instance
// for out-of-range selects.
module tb_mux_pipe_n;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_pipe_n_if #(.WIDTH(32), .N(4)) b4 ();
    mux_pipe_n_if #(.WIDTH(32), .N(3)) b3 ();

    mux_pipe_n #(.WIDTH(32), .N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    mux_pipe_n #(.WIDTH(32), .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
        logic        err;
    } exp_t;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Every pop seen at the DUT output is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (b4.out_valid && b4.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got data 0x%0h expected no entry at %0t",
                             b4.out_data, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pop_data", b4.out_data, e.data);
                    check("pop_sel", 32'(b4.out_sel), 32'(e.sel));
                    check("pop_err", 32'(b4.out_err), 32'(e.err));
                end
            end
            if (b4.flush) sb.delete();
        end
    end

    // Offer one word on the N=4 stage, holding it until accepted; called at posedge+1.
    task automatic send(input logic [1:0] s, input logic [31:0] d);
        bit ok = 0;
        b4.in_valid = 1'b1;
        b4.sel      = s;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (b4.in_ready) begin
                sb.push_back('{d, s, 1'b0});
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        b4.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{2'd0, 32'h11};
        tbl[1] = '{2'd1, 32'h22};
        tbl[2] = '{2'd2, 32'h33};
        tbl[3] = '{2'd3, 32'h44};

        b4.in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
        b4.sel       = '0;
        b4.in_valid  = 1'b0;
        b4.flush     = 1'b0;
        b4.out_ready = 1'b1;
        b3.in_data   = {32'h30, 32'h20, 32'h10};
        b3.sel       = '0;
        b3.in_valid  = 1'b0;
        b3.flush     = 1'b0;
        b3.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 32'(b4.out_valid), 32'd0);
        check("rst_in_ready", 32'(b4.in_ready), 32'd0);
        check("rst_out_data", b4.out_data, 32'd0);
        check("rst_out_sel", 32'(b4.out_sel), 32'd0);
        check("rst_out_err", 32'(b4.out_err), 32'd0);
        check("rst_in_ready3", 32'(b3.in_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_in_ready", 32'(b4.in_ready), 32'd1);

        // Single pulse: visible one cycle after accept, for exactly one cycle
        send(2'd2, 32'h33);
        check("pulse_valid", 32'(b4.out_valid), 32'd1);
        @(posedge clk);
        #1;
        check("pulse_gone", 32'(b4.out_valid), 32'd0);

        // Streaming from the vector table
        for (int i = 0; i < 4; i++) begin
            check("stream_in_ready", 32'(b4.in_ready), 32'd1);
            send(tbl[i].sel, tbl[i].data);
        end
        drain();

        // Stall: two absorbed, third held off until the sink resumes
        b4.out_ready = 1'b0;
        send(2'd0, 32'h11);
        send(2'd1, 32'h22);
        check("stall_in_ready", 32'(b4.in_ready), 32'd0);
        b4.in_valid = 1'b1;
        b4.sel      = 2'd2;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("stall_hold_ready", 32'(b4.in_ready), 32'd0);
            check("stall_head_stable", b4.out_data, 32'h11);
        end
        b4.out_ready = 1'b1;
        send(2'd2, 32'h33);
        drain();

        // Out-of-range select on the N=3 instance, then an in-range one back to back
        b3.sel      = 2'd3;
        b3.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("oor_valid", 32'(b3.out_valid), 32'd1);
        check("oor_data", b3.out_data, 32'd0);
        check("oor_err", 32'(b3.out_err), 32'd1);
        check("oor_sel", 32'(b3.out_sel), 32'd3);
        b3.sel = 2'd2;
        @(posedge clk);
        #1;
        b3.in_valid = 1'b0;
        check("n3_data", b3.out_data, 32'h30);
        check("n3_err", 32'(b3.out_err), 32'd0);
        check("n3_sel", 32'(b3.out_sel), 32'd2);

        // Flush when full with a simultaneous push offer
        b4.out_ready = 1'b0;
        send(2'd0, 32'h11);
        send(2'd1, 32'h22);
        check("pre_flush_full", 32'(b4.in_ready), 32'd0);
        b4.flush    = 1'b1;
        b4.in_valid = 1'b1;
        b4.sel      = 2'd3;
        @(posedge clk);
        #1;
        b4.flush    = 1'b0;
        b4.in_valid = 1'b0;
        check("flush_valid", 32'(b4.out_valid), 32'd0);
        check("flush_in_ready", 32'(b4.in_ready), 32'd1);
        b4.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_stays_empty", 32'(b4.out_valid), 32'd0);

        // Flush with one entry: pop completes, simultaneous push discarded
        send(2'd0, 32'h11);
        b4.flush    = 1'b1;
        b4.in_valid = 1'b1;
        b4.sel      = 2'd3;
        @(posedge clk);
        #1;
        b4.flush    = 1'b0;
        b4.in_valid = 1'b0;
        check("flush1_valid", 32'(b4.out_valid), 32'd0);
        check("flush1_in_ready", 32'(b4.in_ready), 32'd1);

        // Asynchronous reset mid-transfer with two entries held
        b4.out_ready = 1'b0;
        send(2'd2, 32'h33);
        send(2'd3, 32'h44);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(b4.out_valid), 32'd0);
        check("arst_in_ready", 32'(b4.in_ready), 32'd0);
        check("arst_out_data", b4.out_data, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        b4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_arst_in_ready", 32'(b4.in_ready), 32'd1);
        check("post_arst_empty", 32'(b4.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
